// File: rtl/aes128_iter_encryptor_pkg.sv
`default_nettype none
// ---- aes_pack: AES-128 types, tables and round helper functions (rev 1.0) ----
package aes_pack;

  localparam int NUM_ROUNDS = 10;

  typedef logic [15:0][7:0] aes_block_t;
  typedef logic [3:0][7:0]  aes_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_t;

  localparam logic [7:0] SUB_BYTES_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON_TABLE [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Rounds outside 1..10 (idle cycles) select zero instead of indexing out of range.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NUM_ROUNDS; i++)
      if (r == 4'(i + 1)) v = RCON_TABLE[i];
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_block_t sub_bytes(input aes_block_t s);
    aes_block_t o;
    for (int i = 0; i < 16; i++) o[i] = SUB_BYTES_TABLE[s[i]];
    return o;
  endfunction

  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c + r] = s[4*((c + r) % 4) + r];
    return o;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c + 1];
      a2 = s[4*c + 2];
      a3 = s[4*c + 3];
      o[4*c]     = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      o[4*c + 1] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      o[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      o[4*c + 3] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic aes_block_t key_expand(input aes_block_t k, input logic [7:0] rc);
    aes_word_t  w0, w1, w2, w3, t;
    aes_block_t o;
    for (int r = 0; r < 4; r++) begin
      w0[r] = k[r];
      w1[r] = k[4 + r];
      w2[r] = k[8 + r];
      w3[r] = k[12 + r];
    end
    t  = {SUB_BYTES_TABLE[w3[0]], SUB_BYTES_TABLE[w3[3]],
          SUB_BYTES_TABLE[w3[2]], SUB_BYTES_TABLE[w3[1]]};
    w0 = w0 ^ t ^ {24'h000000, rc};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    for (int r = 0; r < 4; r++) begin
      o[r]      = w0[r];
      o[4 + r]  = w1[r];
      o[8 + r]  = w2[r];
      o[12 + r] = w3[r];
    end
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_iter_encryptor_round.sv
`default_nettype none
// ---- aes_round: one combinational AES-128 round with its key step (rev 1.0) ----
module aes_round
  import aes_pack::*;
(
  input  aes_block_t  state_i,
  input  aes_block_t  key_i,
  input  logic [3:0]  round_i,
  output aes_block_t  state_o,
  output aes_block_t  key_o
);

  aes_block_t w_shifted;

  assign key_o     = key_expand(key_i, rcon(round_i));
  assign w_shifted = shift_rows(sub_bytes(state_i));
  assign state_o   = ((round_i == 4'(NUM_ROUNDS)) ? w_shifted : mix_columns(w_shifted)) ^ key_o;

endmodule
`default_nettype wire

// File: rtl/aes128_iter_encryptor.sv
`default_nettype none
// ---- aes128_iter_encryptor: iterative AES-128 core, ROUNDS_PER_CYCLE rounds per clock (rev 1.0) ----
module aes128_iter_encryptor
  import aes_pack::*;
#(
  parameter int ROUNDS_PER_CYCLE    = 1,
  parameter int DATA_WIDTH_IN_BYTES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH_IN_BYTES*8-1:0] in_data,
  input  logic [DATA_WIDTH_IN_BYTES*8-1:0] in_key,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0] out_data,
  output logic                             busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes128_iter_encryptor: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end
  if (DATA_WIDTH_IN_BYTES != 16) begin : g_bad_width
    $error("aes128_iter_encryptor: DATA_WIDTH_IN_BYTES must be 16");
  end

  // Round index of the first round in the final clock of a block.
  localparam logic [3:0] c_last_start = 4'(NUM_ROUNDS - ROUNDS_PER_CYCLE + 1);

  aes_fsm_t   state_q;
  aes_block_t blk_q, key_q, out_data_q;
  aes_block_t blk_d, key_d;
  logic [3:0] round_q;
  logic       out_valid_q;

  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
    aes_block_t w_s_in, w_k_in, w_s_out, w_k_out;
    if (k == 0) begin : g_first
      assign w_s_in = blk_q;
      assign w_k_in = key_q;
    end else begin : g_chain
      assign w_s_in = g_round[k-1].w_s_out;
      assign w_k_in = g_round[k-1].w_k_out;
    end
    aes_round u_round (
      .state_i (w_s_in),
      .key_i   (w_k_in),
      .round_i (round_q + 4'(k)),
      .state_o (w_s_out),
      .key_o   (w_k_out)
    );
  end

  assign blk_d = g_round[ROUNDS_PER_CYCLE-1].w_s_out;
  assign key_d = g_round[ROUNDS_PER_CYCLE-1].w_k_out;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      key_q       <= '0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            blk_q   <= in_data ^ in_key;
            key_q   <= in_key;
            round_q <= 4'd1;
            state_q <= RUN;
          end
        end
        RUN: begin
          blk_q   <= blk_d;
          key_q   <= key_d;
          round_q <= round_q + 4'(ROUNDS_PER_CYCLE);
          if (round_q == c_last_start) begin
            out_data_q  <= blk_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              blk_q   <= in_data ^ in_key;
              key_q   <= in_key;
              round_q <= 4'd1;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes128_iter_encryptor.sv
`default_nettype none
// ---- tb_aes128_iter_encryptor: self-checking bench with reference AES-128 model and scoreboard (rev 1.0) ----
module tb_aes128_iter_encryptor;

  localparam logic [127:0] C1_KEY  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C1_PT   = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1_CT   = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] ZERO_CT = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, in_key, out_data;

  logic         m_valid;
  logic         ov_m [3];
  logic         ir_m [3];
  logic         bz_m [3];
  logic [127:0] od_m [3];

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;
  int n_in   = 0;
  int n_out  = 0;

  logic [127:0] exp_q[$];
  int           start_q[$];
  logic [7:0]   sb [256];

  always #5 clk = ~clk;

  aes128_iter_encryptor #(.ROUNDS_PER_CYCLE(1), .DATA_WIDTH_IN_BYTES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  aes128_iter_encryptor #(.ROUNDS_PER_CYCLE(2), .DATA_WIDTH_IN_BYTES(16)) u_rpc2 (
    .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(ir_m[0]), .in_data(128'h0),
    .in_key(128'h0), .out_valid(ov_m[0]), .out_ready(1'b1), .out_data(od_m[0]), .busy(bz_m[0]));

  aes128_iter_encryptor #(.ROUNDS_PER_CYCLE(5), .DATA_WIDTH_IN_BYTES(16)) u_rpc5 (
    .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(ir_m[1]), .in_data(128'h0),
    .in_key(128'h0), .out_valid(ov_m[1]), .out_ready(1'b1), .out_data(od_m[1]), .busy(bz_m[1]));

  aes128_iter_encryptor #(.ROUNDS_PER_CYCLE(10), .DATA_WIDTH_IN_BYTES(16)) u_rpc10 (
    .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(ir_m[2]), .in_data(128'h0),
    .in_key(128'h0), .out_valid(ov_m[2]), .out_ready(1'b1), .out_data(od_m[2]), .busy(bz_m[2]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse and affine map, independent of the RTL table.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] ct;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      w[i] = {key[32*i +: 8], key[32*i+8 +: 8], key[32*i+16 +: 8], key[32*i+24 +: 8]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[8*i +: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) tmp[4*c+r] = st[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
        if (rnd < 10) begin
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[8*i +: 8] = st[i];
    return ct;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: push model result on input handshake, check latency/data on arrival, pop on output handshake.
  initial begin : monitor
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        start_q.delete();
        prev_ov = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          exp_q.push_back(aes_ref(in_data, in_key));
          start_q.push_back(cyc + 1);
          n_in++;
        end
        if (out_valid && !prev_ov) begin
          check("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
          if (exp_q.size() != 0) begin
            check("latency", 128'(cyc - start_q[0]), 128'd10);
            check("sb_data", out_data, exp_q[0]);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(start_q.pop_front());
          end
          n_out++;
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(input int max, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    check(tag, 128'(out_valid), 128'd1);
  endtask

  initial begin
    int lat [3];
    int in0, out0;
    build_sbox();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b1; m_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    rst = 1'b0;
    tick();

    // FIPS-197 C.1 with exact latency and busy tracking
    in_data = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 128'hdeadbeef; in_key = 128'h12345;
    for (int k = 0; k < 9; k++) begin
      check("c1_busy", 128'(busy), 128'd1);
      check("c1_no_early_valid", 128'(out_valid), 128'd0);
      tick();
    end
    tick();
    check("c1_valid_at_10", 128'(out_valid), 128'd1);
    check("c1_data", out_data, C1_CT);
    check("c1_busy_done", 128'(busy), 128'd1);
    tick();
    check("c1_idle_valid", 128'(out_valid), 128'd0);
    check("c1_idle_busy", 128'(busy), 128'd0);
    check("c1_hold_data", out_data, C1_CT);

    // All-zero vector across every legal unroll factor
    in_data = '0; in_key = '0; in_valid = 1'b1; m_valid = 1'b1;
    tick();
    in_valid = 1'b0; m_valid = 1'b0;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      for (int i = 0; i < 3; i++)
        if (ov_m[i] && lat[i] == 0) begin
          lat[i] = n;
          check("rpc_zero_data", od_m[i], ZERO_CT);
        end
    end
    check("rpc2_latency", 128'(lat[0]), 128'd5);
    check("rpc5_latency", 128'(lat[1]), 128'd2);
    check("rpc10_latency", 128'(lat[2]), 128'd1);
    check("rpc1_zero_data", out_data, ZERO_CT);

    // Backpressure: result held, inputs blocked, single-cycle release
    out_ready = 1'b0; in_data = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
    tick();
    in_data = '0; in_key = '0;
    wait_ov(20, "bp_out_valid_timeout");
    for (int k = 0; k < 7; k++) begin
      check("bp_valid_held", 128'(out_valid), 128'd1);
      check("bp_data_held", out_data, C1_CT);
      check("bp_in_ready_low", 128'(in_ready), 128'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 128'(out_valid), 128'd0);
    check("bp_release_busy", 128'(busy), 128'd0);
    check("bp_release_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    tick();

    // Back-to-back: second block accepted on the first output handshake
    in_data = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
    tick();
    in_data = '0; in_key = '0;
    wait_ov(20, "b2b_first_timeout");
    check("b2b_first_data", out_data, C1_CT);
    check("b2b_in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_rerun_busy", 128'(busy), 128'd1);
    check("b2b_rerun_valid", 128'(out_valid), 128'd0);
    wait_ov(20, "b2b_second_timeout");
    check("b2b_second_data", out_data, ZERO_CT);
    tick();

    // Asynchronous reset in the middle of a run
    in_data = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_out_data", out_data, 128'd0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_in_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ov(20, "arst_c1_timeout");
    check("arst_c1_data", out_data, C1_CT);
    tick();

    // Random regression against the reference model
    in0 = n_in; out0 = n_out;
    for (int n = 0; n < 40000 && (n_in - in0) < 1000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_key    = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    tick();
    check("rand_blocks_in", 128'(n_in - in0), 128'd1000);
    check("rand_blocks_out", 128'(n_out - out0), 128'd1000);
    check("rand_sb_empty", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
